// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response channels and the decode-side instruction channel.
// master = fetch unit, slave = memory plus the consuming control stage.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC owner issuing word requests to a variable-latency memory, buffering
// up to DEPTH returned words with their PCs for the control stage; flushes on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misaligned,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t         state_q;
    logic [31:0]    fpc_q;
    logic [CW-1:0]  cnt_q, out_q, drop_q;
    logic [CW-1:0]  cnt_d, out_d, drop_d;
    logic [AW-1:0]  rd_q, wr_q, trd_q, twr_q;
    logic           misaligned_q;
    logic [31:0]    data_q [DEPTH];
    logic [31:0]    pc_q   [DEPTH];
    logic [31:0]    tag_q  [DEPTH];
    logic           redir, rsp, push, pop, req_fire, credit;

    // Stale in-flight requests keep holding credit until their responses drain.
    always_comb begin
        redir    = redirect_valid & (state_q != BOOT);
        rsp      = bus.imem_rsp_valid;
        credit   = ({1'b0, cnt_q} + {1'b0, out_q}) < (CW + 1)'(DEPTH);
        req_fire = bus.imem_req_valid & bus.imem_req_ready;
        pop      = bus.inst_valid & bus.inst_ready;
        push     = rsp & !redir & (drop_q == '0);
        out_d    = out_q + CW'(req_fire) - CW'(rsp);
        drop_d   = redir ? out_q - CW'(rsp) : drop_q - CW'(rsp && drop_q != '0);
        cnt_d    = redir ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    assign bus.imem_req_valid = (state_q == RUN) & !redirect_valid & credit;
    assign bus.imem_req_addr  = fpc_q;
    assign bus.inst_valid     = (cnt_q != '0) & !redirect_valid;
    assign bus.inst_data      = (cnt_q != '0) ? data_q[rd_q] : '0;
    assign bus.inst_pc        = (cnt_q != '0) ? pc_q[rd_q] : '0;
    assign bus.inst_pc_plus4  = (cnt_q != '0) ? pc_q[rd_q] + 32'd4 : '0;
    assign misaligned         = misaligned_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            fpc_q        <= RESET_PC;
            cnt_q        <= '0;
            out_q        <= '0;
            drop_q       <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            trd_q        <= '0;
            twr_q        <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= (state_q == BOOT || fetch_en) ? RUN : HOLD;
            fpc_q        <= redir ? {redirect_pc[31:2], 2'b00} : req_fire ? fpc_q + 32'd4 : fpc_q;
            misaligned_q <= redir & (redirect_pc[1:0] != 2'b00);
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
            rd_q         <= redir ? '0 : rd_q + AW'(pop);
            wr_q         <= redir ? '0 : wr_q + AW'(push);
            trd_q        <= trd_q + AW'(rsp);
            twr_q        <= twr_q + AW'(req_fire);
        end
    end

    // PC tags follow requests in order, so stale tags are consumed by their dropped responses.
    always_ff @(posedge clk) begin
        if (req_fire) tag_q[twr_q] <= fpc_q;
        if (push) begin
            data_q[wr_q] <= bus.imem_rsp_data;
            pc_q[wr_q]   <= tag_q[trd_q];
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; expected {pc, word} pushed on each accepted request,
// popped and compared on each instruction handshake, with an in-order memory model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        misaligned;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misaligned     (misaligned),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t        sb[$];
    mreq_t       mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          reqs = 0;
    int          pops = 0;
    logic [31:0] exp_req_pc = '0;
    logic [31:0] last_pop_pc = '0;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // One clock: memory drives its response at the falling edge, handshakes are scored just after.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = img(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        #1;
        if (redirect_valid) begin
            checks++;
            if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_block: inst_valid=%0b req_valid=%0b required 0 0", bus.inst_valid, bus.imem_req_valid);
            end
            sb.delete();
            exp_req_pc = {redirect_pc[31:2], 2'b00};
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            checks++;
            if (bus.imem_req_addr !== exp_req_pc) begin
                errors++;
                $display("FAIL req_addr: got %h required %h", bus.imem_req_addr, exp_req_pc);
            end
            sb.push_back('{exp_req_pc, img(exp_req_pc)});
            mq.push_back('{bus.imem_req_addr, cyc + lat});
            exp_req_pc += 32'd4;
            reqs++;
        end
        if (bus.inst_valid && bus.inst_ready) begin
            pops++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL inst_unexpected: got pc %h data %h required no instruction", bus.inst_pc, bus.inst_data);
            end else begin
                e = sb.pop_front();
                if (bus.inst_pc !== e.pc || bus.inst_data !== e.data || bus.inst_pc_plus4 !== e.pc + 32'd4) begin
                    errors++;
                    $display("FAIL inst: got pc %h data %h pc4 %h required pc %h data %h pc4 %h",
                             bus.inst_pc, bus.inst_data, bus.inst_pc_plus4, e.pc, e.data, e.pc + 32'd4);
                end
            end
            last_pop_pc = bus.inst_pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_pops(input int n, input int budget);
        int start = pops;
        for (int k = 0; k < budget && pops - start < n; k++) step();
        checks++;
        if (pops - start < n) begin
            errors++;
            $display("FAIL pop_timeout: got %0d pops required %0d", pops - start, n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fetch_en = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.inst_ready = 1'b1;
        mq.delete();
        sb.delete();
        exp_req_pc = 32'h0;
        reqs = 0;
        pops = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || misaligned !== 1'b0 ||
            bus.inst_data !== 32'h0 || bus.inst_pc !== 32'h0 || bus.imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req_valid=%0b inst_valid=%0b mis=%0b data=%h pc=%h addr=%h required 0",
                     bus.imem_req_valid, bus.inst_valid, misaligned, bus.inst_data, bus.inst_pc, bus.imem_req_addr);
        end
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        do_reset();
        lat = 1;
        step();
        checks++;
        if (reqs !== 0) begin
            errors++;
            $display("FAIL boot_no_req: got %0d requests required 0", reqs);
        end
        step();
        checks++;
        if (reqs !== 1) begin
            errors++;
            $display("FAIL first_req: got %0d requests required 1", reqs);
        end
        run_until_pops(4, 40);
        checks++;
        if (last_pop_pc !== 32'hC) begin
            errors++;
            $display("FAIL seq_last_pc: got %h required %h", last_pop_pc, 32'hC);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat = 1;
        bus.inst_ready = 1'b0;
        repeat (8) step();
        checks++;
        if (reqs !== 2 || bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL credit_stall: reqs=%0d req_valid=%0b inst_valid=%0b required 2 0 1",
                     reqs, bus.imem_req_valid, bus.inst_valid);
        end
        bus.inst_ready = 1'b1;
        run_until_pops(2, 10);
        repeat (2) step();
        checks++;
        if (reqs < 3) begin
            errors++;
            $display("FAIL resume_req: got %0d requests required at least 3", reqs);
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        lat = 3;
        for (int k = 0; k < 10 && reqs < 2; k++) step();
        checks++;
        if (reqs !== 2) begin
            errors++;
            $display("FAIL drop_setup: got %0d requests required 2", reqs);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        run_until_pops(1, 30);
        checks++;
        if (last_pop_pc !== 32'h100) begin
            errors++;
            $display("FAIL drop_target: got %h required %h", last_pop_pc, 32'h100);
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (misaligned !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_pulse: got %0b required 1", misaligned);
        end
        step();
        checks++;
        if (misaligned !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_width: got %0b required 0", misaligned);
        end
        run_until_pops(1, 30);
        checks++;
        if (last_pop_pc !== 32'h100) begin
            errors++;
            $display("FAIL misaligned_target: got %h required %h", last_pop_pc, 32'h100);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (misaligned !== 1'b0) begin
            errors++;
            $display("FAIL aligned_no_pulse: got %0b required 0", misaligned);
        end
    endtask

    task automatic test_redirect_collision();
        int p;
        do_reset();
        lat = 2;
        bus.inst_ready = 1'b0;
        repeat (4) step();
        p = pops;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        bus.inst_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (bus.imem_rsp_valid !== 1'b1 || pops !== p) begin
            errors++;
            $display("FAIL collision: rsp_valid=%0b pops=%0d required 1 %0d", bus.imem_rsp_valid, pops, p);
        end
        run_until_pops(1, 30);
        checks++;
        if (last_pop_pc !== 32'h300) begin
            errors++;
            $display("FAIL collision_target: got %h required %h", last_pop_pc, 32'h300);
        end
    endtask

    task automatic test_fetch_hold();
        int r;
        logic [31:0] p;
        do_reset();
        lat = 3;
        for (int k = 0; k < 10 && reqs < 1; k++) step();
        fetch_en = 1'b0;
        step();
        r = reqs;
        repeat (8) step();
        checks++;
        if (reqs !== r || bus.imem_req_valid !== 1'b0 || sb.size() !== 0 || pops !== r) begin
            errors++;
            $display("FAIL hold: reqs=%0d req_valid=%0b pending=%0d pops=%0d required %0d 0 0 %0d",
                     reqs, bus.imem_req_valid, sb.size(), pops, r, r);
        end
        p = last_pop_pc;
        fetch_en = 1'b1;
        run_until_pops(1, 30);
        checks++;
        if (last_pop_pc !== p + 32'd4) begin
            errors++;
            $display("FAIL hold_resume: got %h required %h", last_pop_pc, p + 32'd4);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        lat = 2;
        repeat (7) step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || misaligned !== 1'b0 ||
            bus.inst_data !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst_pc_plus4 !== 32'h0 ||
            bus.imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL midreset: req_valid=%0b inst_valid=%0b data=%h pc=%h pc4=%h addr=%h required 0",
                     bus.imem_req_valid, bus.inst_valid, bus.inst_data, bus.inst_pc, bus.inst_pc_plus4, bus.imem_req_addr);
        end
        do_reset();
        run_until_pops(2, 30);
        checks++;
        if (last_pop_pc !== 32'h4) begin
            errors++;
            $display("FAIL midreset_restart: got %h required %h", last_pop_pc, 32'h4);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step();
        for (int k = 0; k < 400; k++) begin
            bus.inst_ready = 1'($urandom_range(0, 1));
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = 32'($urandom_range(0, 4095));
            lat = $urandom_range(1, 4);
            step();
        end
        redirect_valid = 1'b0;
        bus.inst_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        checks++;
        if (pops < 40) begin
            errors++;
            $display("FAIL random_throughput: got %0d pops required at least 40", pops);
        end
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.inst_ready = 1'b1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_drop();
        test_misaligned();
        test_redirect_collision();
        test_fetch_hold();
        test_midreset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
